muldiv_unit: RTL and testbench

Parametrised multi-cycle M-extension execute unit: multiply (MUL/MULH/MULHSU/MULHU) through a configurable-depth pipeline, plus DIV/DIVU/REM/REMU with an iterative radix-2 divider. It sits beside the EX-stage ALU, taking operands after forwarding. It replaces the fixed one-cycle mul_stall scheme with a valid/ready handshake. Results are held until the writeback side accepts them. The unit also supports a pipeline flush.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Issue/result handshake between the EX stage and the M-extension execute unit.
// The issuing pipeline is the master; the execute unit is the slave.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output in_valid, op, op_a, op_b, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, op, op_a, op_b, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: pipelined multiplier plus a radix-2
// restoring divider, with a valid/ready handshake on both issue and result.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic     CLK,
  input  logic     nrst,
  input  logic     flush,
  muldiv_if.slave  bus
);

  localparam int CW   = $clog2((XLEN > MUL_STAGES) ? XLEN : MUL_STAGES) + 1;
  localparam int TAIL = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] res_q;
  logic            neg_q;
  logic            neg_r;
  logic            out_valid_q;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] pipe [MUL_STAGES];

  // Issue-side decode, only consulted on the accept edge.
  logic            accept;
  logic            is_div_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign bus.in_ready  = (state == S_IDLE) & nrst;
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign is_div_in = bus.op[2];
  assign a_neg_in  = ~bus.op[0] & bus.op_a[XLEN-1];
  assign b_neg_in  = ~bus.op[0] & bus.op_b[XLEN-1];
  assign div_zero  = (bus.op_b == '0);
  assign div_ovf   = ~bus.op[0] & (bus.op_a == MIN_INT) & (bus.op_b == '1);
  assign special   = is_div_in & (div_zero | div_ovf);
  // op[1] selects remainder; overflow quotient equals the dividend itself.
  assign special_res = bus.op[1] ? (div_zero ? bus.op_a : '0)
                                 : (div_zero ? '1 : bus.op_a);

  // Multiply: sign-extending to 2*XLEN gives the same low 2*XLEN product bits
  // as the XLEN+1-bit signed/unsigned extension.
  logic              a_sx;
  logic              b_sx;
  logic [2*XLEN-1:0] a_wide;
  logic [2*XLEN-1:0] b_wide;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mul_tail;
  logic [XLEN-1:0]   mul_res;

  assign a_sx     = ((op_q == 3'd1) | (op_q == 3'd2)) & a_q[XLEN-1];
  assign b_sx     = (op_q == 3'd1) & b_q[XLEN-1];
  assign a_wide   = {{XLEN{a_sx}}, a_q};
  assign b_wide   = {{XLEN{b_sx}}, b_q};
  assign prod     = a_wide * b_wide;
  assign mul_tail = (MUL_STAGES == 1) ? prod : pipe[TAIL];
  assign mul_res  = (op_q[1:0] == 2'd0) ? mul_tail[XLEN-1:0] : mul_tail[2*XLEN-1:XLEN];

  // Divide: a_q shifts the dividend out and the quotient in, one bit per cycle.
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  assign r_sh    = {rem_q, a_q[XLEN-1]};
  assign diff    = r_sh - {1'b0, b_q};
  assign fits    = ~diff[XLEN];
  assign q_fix   = neg_q ? -a_q : a_q;
  assign r_fix   = neg_r ? -rem_q : rem_q;
  assign div_res = op_q[1] ? r_fix : q_fix;

  // NOTE: the product chain is pure datapath qualified by the FSM counter, so it
  // carries no reset; stale contents are never selected into res.
  always_ff @(posedge CLK) begin
    if (state == S_MUL) begin
      pipe[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge value, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!nrst || flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= bus.op;
            a_q   <= (is_div_in & a_neg_in) ? -bus.op_a : bus.op_a;
            b_q   <= (is_div_in & b_neg_in) ? -bus.op_b : bus.op_b;
            rem_q <= '0;
            neg_q <= a_neg_in ^ b_neg_in;
            neg_r <= a_neg_in;
            cnt   <= '0;
            if (!is_div_in) begin
              state <= S_MUL;
            end else if (special) begin
              res_q <= special_res;
              state <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt == CW'(MUL_STAGES - 1)) begin
            res_q       <= mul_res;
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (cnt == CW'(XLEN)) begin
            res_q       <= div_res;
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= S_DONE;
          end else begin
            rem_q <= fits ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
            a_q   <= {a_q[XLEN-2:0], fits};
            cnt   <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Special divides enter DONE with out_valid low and raise it here.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32, MUL_STAGES=2): latency,
// results, special divides, backpressure, flush and mid-operation reset.
module tb_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic CLK   = 1'b0;
  logic nrst  = 1'b0;
  logic flush = 1'b0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .CLK   (CLK),
    .nrst  (nrst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge; all driving and sampling happens there.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one edge, then scramble the operands to show they were latched.
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.op_a     = a;
    bus.op_b     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = ~op;
    bus.op_a     = ~a;
    bus.op_b     = a ^ b;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat, output logic [XLEN-1:0] r);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 100);
    r = bus.res;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     output logic rdy, output int lat, output logic [XLEN-1:0] r);
    rdy = bus.in_ready;
    issue(op, a, b);
    wait_result(lat, r);
    ack();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 00000000", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready); end
    nrst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %b want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_mul();
    logic [2:0]      ops [4] = '{OP_MULH, OP_MUL, OP_MULHSU, OP_MULHU};
    logic [XLEN-1:0] av  [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] bv  [4] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] ev  [4] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic rdy; int lat; logic [XLEN-1:0] r;
    for (int i = 0; i < 4; i++) begin
      run(ops[i], av[i], bv[i], rdy, lat, r);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mul%0d_in_ready: got %b want 1", i, rdy); end
      checks++; if (lat != MUL_STAGES) begin errors++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, MUL_STAGES); end
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL mul%0d_res: got %h want %h", i, r, ev[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]      ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [XLEN-1:0] av  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [XLEN-1:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [XLEN-1:0] ev  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic rdy; int lat; logic [XLEN-1:0] r;
    for (int i = 0; i < 4; i++) begin
      run(ops[i], av[i], bv[i], rdy, lat, r);
      checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, XLEN + 1); end
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL div%0d_res: got %h want %h", i, r, ev[i]); end
    end
  endtask

  task automatic test_special();
    logic [2:0]      ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
    logic [XLEN-1:0] av  [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [XLEN-1:0] bv  [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] ev  [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    logic rdy; int lat; logic [XLEN-1:0] r;
    for (int i = 0; i < 4; i++) begin
      run(ops[i], av[i], bv[i], rdy, lat, r);
      checks++; if (lat != 1) begin errors++; $display("FAIL special%0d_latency: got %0d want 1", i, lat); end
      checks++; if (r !== ev[i]) begin errors++; $display("FAIL special%0d_res: got %h want %h", i, r, ev[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [XLEN-1:0] r;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_result(lat, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL bp_res: got %h want 0000000e", r); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.res !== 32'd14 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b res=%h in_ready=%b busy=%b want 1/0000000e/0/1",
                 i, bus.out_valid, bus.res, bus.in_ready, bus.busy);
      end
    end
    ack();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_flush();
    logic rdy; int lat; logic [XLEN-1:0] r;
    bit seen_valid;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid) begin errors++; $display("FAIL flush_no_result: out_valid rose after flush, want never"); end
    run(OP_MUL, 32'd3, 32'd5, rdy, lat, r);
    checks++; if (lat != MUL_STAGES) begin errors++; $display("FAIL flush_mul_latency: got %0d want %0d", lat, MUL_STAGES); end
    checks++; if (r !== 32'd15) begin errors++; $display("FAIL flush_mul_res: got %h want 0000000f", r); end
  endtask

  task automatic test_reset_mid();
    logic rdy; int lat; logic [XLEN-1:0] r;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    nrst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.res !== 32'h0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: out_valid=%b res=%h busy=%b in_ready=%b want all 0",
               bus.out_valid, bus.res, bus.busy, bus.in_ready);
    end
    nrst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    tick();
    run(OP_MUL, 32'd3, 32'd5, rdy, lat, r);
    checks++; if (r !== 32'd15) begin errors++; $display("FAIL rstmid_mul_res: got %h want 0000000f", r); end
  endtask

  // A request held high while busy must wait for the gap cycle after the result is taken.
  task automatic test_back_to_back();
    int lat; logic [XLEN-1:0] r;
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd5;
    tick();
    bus.op_a = 32'd7;
    bus.op_b = 32'd9;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy);
    end
    wait_result(lat, r);
    checks++; if (r !== 32'd15) begin errors++; $display("FAIL b2b_first_res: got %h want 0000000f", r); end
    ack();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_result(lat, r);
    checks++; if (lat != MUL_STAGES) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, MUL_STAGES); end
    checks++; if (r !== 32'd63) begin errors++; $display("FAIL b2b_second_res: got %h want 0000003f", r); end
    ack();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
